reg_file_xfer: RTL and testbench

- Parametrised successor of the CPU register file: NREG scalar registers of DW bits plus NBM wide bitmap registers of BMW bits.
- Two combinational scalar read ports and one bitmap read port, with same-cycle write-to-read bypass.
- Adds a synchronous reset and a bitmap streaming engine that moves one bitmap register to or from a narrow BEAT_W valid/ready bus, one beat per handshake.
- Sits in the CPU datapath; the streaming port connects to the audio/memory interconnect.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/bm_stream_engine.sv | 121 ++++++++++++
 rtl/reg_file_xfer.sv | 112 +++++++++++
 tb/tb_reg_file_xfer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register file with its bitmap streaming engine.
//   xfer_state_e       - streaming engine state (idle, stream out, stream in)
//   XFER_OUT / XFER_IN - values of the xfer_dir input
//   DEF_*              - default widths used as parameter defaults
package rf_pkg;

  typedef enum logic [1:0] {
    XS_IDLE = 2'd0,
    XS_OUT  = 2'd1,
    XS_IN   = 2'd2
  } xfer_state_e;

  localparam logic XFER_OUT = 1'b0;
  localparam logic XFER_IN  = 1'b1;

  localparam int DEF_DW     = 16;
  localparam int DEF_BMW    = 1536;
  localparam int DEF_BEAT_W = 64;

endpackage

// File: rtl/bm_stream_engine.sv
// bm_stream_engine: moves one bitmap register to or from a BEAT_W valid/ready bus.
//   start/dir/addr     - transfer request, sampled only while idle
//   src_data           - bypassed contents of bitmap register `addr` (snapshot source)
//   busy/done          - not-idle flag and one-cycle completion pulse
//   out_valid/out_data/out_ready - outbound beats, beat 0 carries the LSBs
//   in_valid/in_data/in_ready    - inbound beats
//   commit/commit_addr/commit_data - full-register write request on the last inbound beat
module bm_stream_engine
  import rf_pkg::*;
#(
  parameter int NBM    = 3,
  parameter int BMW    = DEF_BMW,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int BAW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [BAW-1:0]    addr,
  input  logic [BMW-1:0]    src_data,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_data,
  output logic              in_ready,
  output logic              commit,
  output logic [BAW-1:0]    commit_addr,
  output logic [BMW-1:0]    commit_data
);

  localparam int NBEAT = BMW / BEAT_W;
  localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CW-1:0]  LAST  = CW'(NBEAT - 1);
  localparam logic [BAW:0]   NBM_L = (BAW + 1)'(NBM);

  xfer_state_e     state_q;
  logic [CW-1:0]   beat_q;
  logic [BMW-1:0]  shadow_q;
  logic [BMW-1:0]  shadow_merged;
  logic [BAW-1:0]  addr_q;
  logic            done_q;
  logic            addr_ok;
  logic            last;

  assign addr_ok = {1'b0, addr} < NBM_L;
  assign last    = (beat_q == LAST);

  // Shadow with the current inbound beat already placed, so the final commit
  // carries the last beat without waiting another cycle.
  always_comb begin
    shadow_merged = shadow_q;
    shadow_merged[int'(beat_q) * BEAT_W +: BEAT_W] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= XS_IDLE;
      beat_q   <= '0;
      shadow_q <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        XS_IDLE: begin
          if (start) begin
            if (!addr_ok) begin
              done_q <= 1'b1;
            end else if (dir == XFER_OUT) begin
              shadow_q <= src_data;
              beat_q   <= '0;
              state_q  <= XS_OUT;
            end else begin
              addr_q  <= addr;
              beat_q  <= '0;
              state_q <= XS_IN;
            end
          end
        end
        XS_OUT: begin
          if (out_ready) begin
            if (last) begin
              beat_q  <= '0;
              state_q <= XS_IDLE;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        XS_IN: begin
          if (in_valid) begin
            shadow_q <= shadow_merged;
            if (last) begin
              beat_q  <= '0;
              state_q <= XS_IDLE;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= XS_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != XS_IDLE);
  assign done        = done_q;
  assign out_valid   = (state_q == XS_OUT);
  assign out_data    = out_valid ? shadow_q[int'(beat_q) * BEAT_W +: BEAT_W] : '0;
  assign in_ready    = (state_q == XS_IN);
  assign commit      = in_ready && in_valid && last;
  assign commit_addr = addr_q;
  assign commit_data = shadow_merged;

endmodule

// File: rtl/reg_file_xfer.sv
// reg_file_xfer: NREG x DW scalar register file plus NBM x BMW bitmap registers,
// with a streaming engine that moves a bitmap register over a BEAT_W bus.
//   rd_addr_1/rd_data_1, rd_addr_2/rd_data_2 - combinational scalar reads (write bypass)
//   wr_addr/wr_data/wr                       - scalar write
//   rbm_addr/rbm_data                        - combinational bitmap read (write bypass)
//   wbm_addr/wbm_data/wbm                    - bitmap write (out-of-range address ignored)
//   xfer_*, out_*, in_*                      - streaming engine control and beat buses
module reg_file_xfer
  import rf_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int DW     = DEF_DW,
  parameter int NBM    = 3,
  parameter int BMW    = DEF_BMW,
  parameter int BEAT_W = DEF_BEAT_W,
  localparam int AW    = $clog2(NREG),
  localparam int BAW   = (NBM > 1) ? $clog2(NBM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_addr_1,
  output logic [DW-1:0]     rd_data_1,
  input  logic [AW-1:0]     rd_addr_2,
  output logic [DW-1:0]     rd_data_2,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              wr,
  input  logic [BAW-1:0]    rbm_addr,
  output logic [BMW-1:0]    rbm_data,
  input  logic [BAW-1:0]    wbm_addr,
  input  logic [BMW-1:0]    wbm_data,
  input  logic              wbm,
  input  logic              xfer_start,
  input  logic              xfer_dir,
  input  logic [BAW-1:0]    xfer_addr,
  output logic              xfer_busy,
  output logic              xfer_done,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_data,
  output logic              in_ready
);

  if ((BMW % BEAT_W) != 0) begin : g_bad_beat_w
    $error("reg_file_xfer: BMW must be a multiple of BEAT_W");
  end

  localparam logic [BAW:0] NBM_L = (BAW + 1)'(NBM);

  logic [DW-1:0]  rf_q [NREG];
  logic [BMW-1:0] bm_q [NBM];

  logic           wbm_ok;
  logic [BMW-1:0] src_data;
  logic           commit;
  logic [BAW-1:0] commit_addr;
  logic [BMW-1:0] commit_data;

  assign wbm_ok = wbm && ({1'b0, wbm_addr} < NBM_L);

  // Bitmap read: out-of-range addresses read as zero, a same-cycle write bypasses.
  function automatic logic [BMW-1:0] bm_read(input logic [BAW-1:0] a);
    if ({1'b0, a} >= NBM_L) return '0;
    if (wbm && wbm_addr == a) return wbm_data;
    return bm_q[a];
  endfunction

  assign rd_data_1 = (wr && wr_addr == rd_addr_1) ? wr_data : rf_q[rd_addr_1];
  assign rd_data_2 = (wr && wr_addr == rd_addr_2) ? wr_data : rf_q[rd_addr_2];
  assign rbm_data  = bm_read(rbm_addr);
  assign src_data  = bm_read(xfer_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      for (int j = 0; j < NBM; j++) bm_q[j] <= '0;
    end else begin
      if (wr) rf_q[wr_addr] <= wr_data;
      if (wbm_ok) bm_q[wbm_addr] <= wbm_data;
      // A direct port write to the same register outranks the stream commit.
      if (commit && !(wbm_ok && wbm_addr == commit_addr)) bm_q[commit_addr] <= commit_data;
    end
  end

  bm_stream_engine #(
    .NBM   (NBM),
    .BMW   (BMW),
    .BEAT_W(BEAT_W),
    .BAW   (BAW)
  ) u_engine (
    .clk        (clk),
    .rst        (rst),
    .start      (xfer_start),
    .dir        (xfer_dir),
    .addr       (xfer_addr),
    .src_data   (src_data),
    .busy       (xfer_busy),
    .done       (xfer_done),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .commit     (commit),
    .commit_addr(commit_addr),
    .commit_data(commit_data)
  );

endmodule

// File: tb/tb_reg_file_xfer.sv
// tb_reg_file_xfer: directed bench for reg_file_xfer with a transaction-level
// reference model compared against the DUT on every negedge.
module tb_reg_file_xfer;

  localparam int NREG   = 16;
  localparam int DW     = 16;
  localparam int NBM    = 3;
  localparam int BMW    = 1536;
  localparam int BEAT_W = 64;
  localparam int NBEAT  = BMW / BEAT_W;
  localparam int AW     = 4;
  localparam int BAW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [AW-1:0]     rd_addr_1 = '0, rd_addr_2 = '0, wr_addr = '0;
  logic [DW-1:0]     rd_data_1, rd_data_2, wr_data = '0;
  logic              wr = 1'b0;
  logic [BAW-1:0]    rbm_addr = '0, wbm_addr = '0, xfer_addr = '0;
  logic [BMW-1:0]    rbm_data, wbm_data = '0;
  logic              wbm = 1'b0, xfer_start = 1'b0, xfer_dir = 1'b0;
  logic              xfer_busy, xfer_done, out_valid, in_ready;
  logic [BEAT_W-1:0] out_data, in_data = '0;
  logic              out_ready = 1'b0, in_valid = 1'b0;

  always #5 clk = ~clk;

  reg_file_xfer #(.NREG(NREG), .DW(DW), .NBM(NBM), .BMW(BMW), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr(wr),
    .rbm_addr(rbm_addr), .rbm_data(rbm_data),
    .wbm_addr(wbm_addr), .wbm_data(wbm_data), .wbm(wbm),
    .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_addr(xfer_addr),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
  );

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bm(input string name, input logic [BMW-1:0] act, input logic [BMW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: bitmap differs, got low word %h, expected low word %h (t=%0t)",
               name, act[63:0], exp[63:0], $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]  m_rf [NREG];
  logic [BMW-1:0] m_bm [NBM];
  logic [BMW-1:0] m_snap;
  int             m_mode;   // 0 idle, 1 streaming out, 2 streaming in
  int             m_beat;
  int             m_addr;
  bit             m_done;
  bit             m_nd;
  bit             m_commit;

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (wr && int'(wr_addr) == a) return wr_data;
    return m_rf[a];
  endfunction

  function automatic logic [BMW-1:0] exp_rbm(input int a);
    if (a >= NBM) return '0;
    if (wbm && int'(wbm_addr) == a) return wbm_data;
    return m_bm[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
      for (int i = 0; i < NBM; i++) m_bm[i] = '0;
      m_snap = '0; m_mode = 0; m_beat = 0; m_addr = 0; m_done = 0;
    end else begin
      m_nd = 0;
      m_commit = 0;
      if (m_mode == 0) begin
        if (xfer_start) begin
          if (int'(xfer_addr) >= NBM) m_nd = 1;
          else if (!xfer_dir) begin m_snap = exp_rbm(int'(xfer_addr)); m_beat = 0; m_mode = 1; end
          else begin m_addr = int'(xfer_addr); m_beat = 0; m_mode = 2; end
        end
      end else if (m_mode == 1) begin
        if (out_ready) begin
          m_beat++;
          if (m_beat == NBEAT) begin m_mode = 0; m_beat = 0; m_nd = 1; end
        end
      end else begin
        if (in_valid) begin
          m_snap[m_beat*BEAT_W +: BEAT_W] = in_data;
          m_beat++;
          if (m_beat == NBEAT) begin m_mode = 0; m_beat = 0; m_nd = 1; m_commit = 1; end
        end
      end
      if (wr) m_rf[wr_addr] = wr_data;
      if (wbm && int'(wbm_addr) < NBM) m_bm[wbm_addr] = wbm_data;
      if (m_commit && !(wbm && int'(wbm_addr) == m_addr)) m_bm[m_addr] = m_snap;
      m_done = m_nd;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data_1", 64'(rd_data_1), 64'(exp_rd(int'(rd_addr_1))));
      chk("rd_data_2", 64'(rd_data_2), 64'(exp_rd(int'(rd_addr_2))));
      chk_bm("rbm_data", rbm_data, exp_rbm(int'(rbm_addr)));
      chk("xfer_busy", 64'(xfer_busy), 64'(m_mode != 0));
      chk("xfer_done", 64'(xfer_done), 64'(m_done));
      chk("out_valid", 64'(out_valid), 64'(m_mode == 1));
      chk("in_ready", 64'(in_ready), 64'(m_mode == 2));
      chk("out_data", out_data, (m_mode == 1) ? m_snap[m_beat*BEAT_W +: BEAT_W] : 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [BMW-1:0]    pat_inc, exp_in, pat5, ones;
  logic [BEAT_W-1:0] rx[$];
  int got, dn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NBEAT; k++) begin
      pat_inc[k*BEAT_W +: BEAT_W] = 64'(k);
      exp_in[k*BEAT_W +: BEAT_W]  = {56'hA5A5A5A5A5A5A5, 8'(k)};
    end
    pat5 = {NBEAT{64'h0123456789ABCDEF}};
    ones = '1;

    // reset
    rst = 1'b1;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      rd_addr_1 = AW'(a); rd_addr_2 = AW'(NREG - 1 - a); rbm_addr = BAW'(a % 4);
      @(negedge clk);
      chk("reset_rd1", 64'(rd_data_1), 64'd0);
      chk("reset_rd2", 64'(rd_data_2), 64'd0);
      chk_bm("reset_rbm", rbm_data, '0);
      chk("reset_busy", 64'({xfer_busy, in_ready, out_valid}), 64'd0);
      tick();
    end

    // scalar write bypass
    wr = 1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_1 = 4'd5;
    @(negedge clk);
    chk("bypass_rd1", 64'(rd_data_1), 64'h0000_0000_0000_BEEF);
    tick();
    wr = 0;
    @(negedge clk);
    chk("stored_rd1", 64'(rd_data_1), 64'h0000_0000_0000_BEEF);
    tick();

    // stream out reg 1 with throttled ready, mid-stream overwrite, ignored start
    wbm = 1; wbm_addr = 2'd1; wbm_data = pat_inc; tick(); wbm = 0;
    xfer_start = 1; xfer_dir = 0; xfer_addr = 2'd1; rbm_addr = 2'd1; tick(); xfer_start = 0;
    got = 0; dn = 0;
    for (int c = 0; c < 300 && !(got == NBEAT && dn > 0); c++) begin
      out_ready  = c[0];
      xfer_start = (c == 5); xfer_dir = 1; xfer_addr = 2'd2;
      wbm = (c == 20); wbm_addr = 2'd1; wbm_data = ones;
      @(negedge clk);
      if (out_valid && out_ready) begin rx.push_back(out_data); got++; end
      if (xfer_done) dn++;
      tick();
    end
    xfer_start = 0; wbm = 0; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (xfer_done) dn++;
      tick();
    end
    chk("out_beat_count", 64'(got), 64'd24);
    for (int k = 0; k < rx.size(); k++) chk($sformatf("out_beat_%0d", k), rx[k], 64'(k));
    chk("out_done_pulses", 64'(dn), 64'd1);

    // stream in to reg 2 with gaps
    xfer_start = 1; xfer_dir = 1; xfer_addr = 2'd2; rbm_addr = 2'd2; tick(); xfer_start = 0;
    for (int k = 0; k < NBEAT; k++) begin
      if (k % 3 == 1) begin in_valid = 0; @(negedge clk); tick(); end
      in_valid = 1; in_data = {56'hA5A5A5A5A5A5A5, 8'(k)};
      if (k == NBEAT - 1) begin
        @(negedge clk);
        chk_bm("in_before_last", rbm_data, '0);
      end
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    chk("in_done", 64'(xfer_done), 64'd1);
    chk_bm("in_committed", rbm_data, exp_in);
    tick();

    // stream in to reg 0 colliding with a port write on the last beat
    xfer_start = 1; xfer_dir = 1; xfer_addr = 2'd0; rbm_addr = 2'd0; tick(); xfer_start = 0;
    for (int k = 0; k < NBEAT; k++) begin
      in_valid = 1; in_data = ~64'(k);
      if (k == NBEAT - 1) begin wbm = 1; wbm_addr = 2'd0; wbm_data = pat5; end
      tick();
    end
    in_valid = 0; wbm = 0;
    @(negedge clk);
    chk("collide_done", 64'(xfer_done), 64'd1);
    chk_bm("collide_wbm_wins", rbm_data, pat5);
    tick();

    // reset in the middle of an outbound stream
    xfer_start = 1; xfer_dir = 0; xfer_addr = 2'd2; tick(); xfer_start = 0;
    out_ready = 1;
    repeat (10) tick();
    @(negedge clk);
    chk("pre_reset_beat10", out_data, {56'hA5A5A5A5A5A5A5, 8'd10});
    rst = 1; tick(); rst = 0; out_ready = 0;
    @(negedge clk);
    chk("abort_busy", 64'(xfer_busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_done", 64'(xfer_done), 64'd0);
    for (int a = 0; a < NREG; a++) begin
      rd_addr_1 = AW'(a); rbm_addr = BAW'(a % NBM);
      @(negedge clk);
      chk("abort_rd1_zero", 64'(rd_data_1), 64'd0);
      chk_bm("abort_rbm_zero", rbm_data, '0);
      tick();
    end

    // invalid transfer address and ignored out-of-range bitmap write
    xfer_start = 1; xfer_dir = 0; xfer_addr = 2'd3; tick(); xfer_start = 0;
    @(negedge clk);
    chk("bad_addr_done", 64'(xfer_done), 64'd1);
    chk("bad_addr_busy", 64'(xfer_busy), 64'd0);
    tick();
    wbm = 1; wbm_addr = 2'd3; wbm_data = ones; rbm_addr = 2'd3;
    @(negedge clk);
    chk_bm("rbm_out_of_range", rbm_data, '0);
    tick();
    wbm = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
